stall_ctrl: RTL and testbench

Hazard/stall controller for the five-stage pipeline: the block that drives the `en` and `flush` inputs of the D→E pipeline register and the enables of the PC and F→D register. It compares operand-use deadlines of the instruction in D against result-ready times of instructions in E and M. It also tracks the multi-cycle multiply/divide unit with an internal busy counter. It stalls F/D and inserts a bubble into E whenever forwarding cannot satisfy a dependency.

---
 rtl/stall_ctrl_pkg.sv | 40 ++++
 rtl/stall_ctrl_md_busy_counter.sv | 35 +++
 rtl/stall_ctrl.sv | 75 +++++++
 tb/tb_stall_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stall_ctrl_pkg                                               |
// | Description : Tuse/Tnew timing encodings, multiply/divide latency          |
// |               defaults and the register-hazard helper for stall_ctrl.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stall_ctrl_pkg;

    typedef logic [1:0] t_time;
    typedef logic [4:0] t_reg;

    localparam t_time TUSE_NOW   = 2'd0;
    localparam t_time TUSE_ONE   = 2'd1;
    localparam t_time TUSE_TWO   = 2'd2;
    localparam t_time TUSE_NEVER = 2'd3;
    localparam t_time TNEW_READY = 2'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam t_reg ZERO_REG = 5'd0;

    // A source conflicts with a producer when it names the same non-zero
    // register and is needed before the producer's result can be forwarded.
    function automatic logic reg_hazard(
        input t_reg  a_src,
        input t_time tuse,
        input t_reg  a_e,
        input t_time tnew_e,
        input t_reg  a_m,
        input t_time tnew_m
    );
        return (a_src != ZERO_REG) &&
               (((a_src == a_e) && (tuse < tnew_e)) ||
                ((a_src == a_m) && (tuse < tnew_m)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_ctrl_md_busy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : md_busy_counter                                              |
// | Description : Occupancy counter for the multi-cycle multiply/divide unit.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic startE,
    input  logic isDivE,
    output logic busy
);

    logic [CNT_W-1:0] r_cnt;

    // A start always reloads, even over a running count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (startE) begin
            r_cnt <= isDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign busy = (r_cnt != '0) && !reset;

endmodule
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stall_ctrl                                                   |
// | Description : Pipeline hazard/stall controller; MDU_STALL_EN adds the      |
// |               multiply/divide busy tracking and MD hazard term.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1D,
    input  logic [4:0] A2D,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic [4:0] A3E,
    input  logic [1:0] TnewE,
    input  logic [4:0] A3M,
    input  logic [1:0] TnewM,
    input  logic       mdD,
    input  logic       startE,
    input  logic       isDivE,
    output logic       enPC,
    output logic       enIFID,
    output logic       flushIDEX,
    output logic       busy
);

    logic w_haz_rs;
    logic w_haz_rt;
    logic w_md_haz;
    logic w_busy;
    logic w_stall;

    assign w_haz_rs = reg_hazard(A1D, TuseRsD, A3E, TnewE, A3M, TnewM);
    assign w_haz_rt = reg_hazard(A2D, TuseRtD, A3E, TnewE, A3M, TnewM);

`ifdef MDU_STALL_EN
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .isDivE (isDivE),
        .busy   (w_busy)
    );

    assign w_md_haz = mdD && (w_busy || startE);
`else
    localparam int c_unused_cfg = MULT_CYCLES + DIV_CYCLES + CNT_W;
    logic w_unused_md;

    assign w_unused_md = &{1'b0, clk, mdD, startE, isDivE};
    assign w_busy      = 1'b0;
    assign w_md_haz    = 1'b0;
`endif

    // Reset masks every stall source so the front end free-runs while held.
    assign w_stall   = !reset && (w_haz_rs || w_haz_rt || w_md_haz);

    assign enPC      = !w_stall;
    assign enIFID    = !w_stall;
    assign flushIDEX = w_stall;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stall_ctrl                                                |
// | Description : Self-checking bench for stall_ctrl (vector table + MD seqs). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stall_ctrl;

    typedef struct {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] a3e;
        logic [1:0] tnew_e;
        logic [4:0] a3m;
        logic [1:0] tnew_m;
        logic       md;
        logic       start;
        logic       isdiv;
        logic       rst;
        logic       exp_stall;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] outs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] A1D, A2D, A3E, A3M;
    logic [1:0] TuseRsD, TuseRtD, TnewE, TnewM;
    logic       mdD, startE, isDivE;
    logic       enPC, enIFID, flushIDEX, busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .A1D       (A1D),
        .A2D       (A2D),
        .TuseRsD   (TuseRsD),
        .TuseRtD   (TuseRtD),
        .A3E       (A3E),
        .TnewE     (TnewE),
        .A3M       (A3M),
        .TnewM     (TnewM),
        .mdD       (mdD),
        .startE    (startE),
        .isDivE    (isDivE),
        .enPC      (enPC),
        .enIFID    (enIFID),
        .flushIDEX (flushIDEX),
        .busy      (busy)
    );

    function automatic vec_t rv(input logic [4:0] a1, input logic [4:0] a2,
                                input logic [1:0] urs, input logic [1:0] urt,
                                input logic [4:0] a3e, input logic [1:0] ne,
                                input logic [4:0] a3m, input logic [1:0] nm,
                                input logic rst, input logic st);
        vec_t v;
        v = '{a1, a2, urs, urt, a3e, ne, a3m, nm, 1'b0, 1'b0, 1'b0, rst, st, 1'b0};
        return v;
    endfunction

    function automatic vec_t mv(input logic md, input logic start, input logic isdiv,
                                input logic rst, input logic st, input logic bz);
        vec_t v;
        v = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, md, start, isdiv, rst, st, bz};
        return v;
    endfunction

    // Drive one cycle's inputs just after the edge, check at the falling edge.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        logic [3:0] act;
        @(posedge clk);
        #1;
        A1D = v.a1; A2D = v.a2; TuseRsD = v.tuse_rs; TuseRtD = v.tuse_rt;
        A3E = v.a3e; TnewE = v.tnew_e; A3M = v.a3m; TnewM = v.tnew_m;
        mdD = v.md; startE = v.start; isDivE = v.isdiv; reset = v.rst;
        e.name = name;
        e.outs = {~v.exp_stall, ~v.exp_stall, v.exp_stall, v.exp_busy};
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        act = {enPC, enIFID, flushIDEX, busy};
        checks++;
        if (act !== got.outs) begin
            errors++;
            $display("FAIL %s: {enPC,enIFID,flushIDEX,busy} got %b expected %b",
                     got.name, act, got.outs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        A1D = '0; A2D = '0; TuseRsD = 2'd3; TuseRtD = 2'd3;
        A3E = '0; TnewE = '0; A3M = '0; TnewM = '0;
        mdD = 1'b0; startE = 1'b0; isDivE = 1'b0;

        //              a1    a2    urs   urt   a3e   ne    a3m   nm   rst  stall
        tbl[0]  = rv(5'd1, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1);
        tbl[1]  = rv(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 5'd1, 2'd1, 1'b0, 1'b0);
        tbl[2]  = rv(5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        tbl[3]  = rv(5'd0, 5'd5, 2'd3, 2'd2, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        tbl[4]  = rv(5'd0, 5'd5, 2'd3, 2'd0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b1);
        tbl[5]  = rv(5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b1);
        tbl[6]  = rv(5'd3, 5'd0, 2'd0, 2'd3, 5'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        tbl[7]  = rv(5'd3, 5'd0, 2'd3, 2'd3, 5'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0);
        tbl[8]  = rv(5'd3, 5'd0, 2'd0, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        tbl[9]  = rv(5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0, 1'b1);
        tbl[10] = rv(5'd2, 5'd0, 2'd0, 2'd3, 5'd2, 2'd0, 5'd2, 2'd1, 1'b0, 1'b1);
        tbl[11] = rv(5'd1, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 5'd0, 2'd0, 1'b1, 1'b0);

        step("reset_idle", rv(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 12; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end
        step("hazard_after_reset", tbl[0]);

`ifdef MDU_STALL_EN
        step("mult_start", mv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int c = 1; c <= 5; c++) begin
            step($sformatf("mult_busy%0d", c), mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        step("mult_done", mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("md_idle", mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        step("div_start", mv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int c = 1; c <= 3; c++) begin
            step($sformatf("div_busy%0d", c), mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        step("div_reset", mv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        step("div_aborted", mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        step("div_full_start", mv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int c = 1; c <= 10; c++) begin
            step($sformatf("div_full%0d", c), mv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        step("div_full_done", mv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`else
        step("nomdu_start", mv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step("nomdu_after", mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("nomdu_div", mv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        step("nomdu_div_after", mv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
